// File: rtl/hid_event_encoder.sv
// hid_event_encoder: periodically snapshots the USB host HID outputs, diffs
// them against the previous snapshot and queues 16-bit events in a FWFT FIFO.
module hid_event_encoder #(
    parameter int FIFO_DEPTH  = 16,
    parameter int POLL_CYCLES = 48000,
    parameter int FREEZE_WAIT = 3
) (
    input  logic                          clk_i,
    input  logic                          rstn,
    output logic                          hid_read,
    input  logic                          hid_keyboard_connected,
    input  logic                          hid_mouse_connected,
    input  logic [7:0]                    hid_keyboard_modifiers,
    input  logic [47:0]                   hid_keyboard_keycodes,
    input  logic [7:0]                    hid_mouse_buttons,
    input  logic [31:0]                   hid_mouse_x,
    input  logic [31:0]                   hid_mouse_y,
    input  logic [31:0]                   hid_mouse_wheel,
    output logic [15:0]                   evt_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TMAX = (POLL_CYCLES > FREEZE_WAIT) ? POLL_CYCLES : FREEZE_WAIT;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] POLL_END = TW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] FRZ_END  = TW'(FREEZE_WAIT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FREEZE  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SCAN    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    step_q, step_d;

    logic [47:0]   cur_keys_q, prev_keys_q;
    logic [7:0]    cur_mods_q, prev_mods_q;
    logic [7:0]    cur_btn_q, prev_btn_q;
    logic [31:0]   cur_mot_q [3];
    logic [31:0]   last_q [3];
    logic [31:0]   last_d [3];
    logic          cur_mc_q;
    logic          roll_q;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [47:0]   cap_keys;
    logic [31:0]   cap_mot [3];
    logic          cap_roll;

    logic          cand_v;
    logic [15:0]   cand_d;
    logic          is_mod, is_brk, is_mk, is_btn, is_mot;
    logic [2:0]    brk_idx, mk_idx;
    logic [7:0]    brk_code, mk_code;
    logic [1:0]    ax;
    logic signed [31:0] diff;
    logic signed [7:0]  clamped;

    logic          pop, full, push_ok;

    function automatic logic [7:0] key_at(input logic [47:0] ks,
                                          input logic [2:0] i);
        logic [7:0] k;
        k = '0;
        for (int j = 0; j < 6; j++)
            if (i == 3'(j)) k = ks[j*8 +: 8];
        return k;
    endfunction

    function automatic logic has_code(input logic [7:0] c,
                                      input logic [47:0] ks);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 6; j++)
            if (ks[j*8 +: 8] == c) hit = 1'b1;
        return hit;
    endfunction

    // a code repeated in a lower slot was already handled as the same key
    function automatic logic seen_before(input logic [7:0] c,
                                         input logic [47:0] ks,
                                         input logic [2:0] n);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 6; j++)
            if (3'(j) < n && ks[j*8 +: 8] == c) hit = 1'b1;
        return hit;
    endfunction

    assign hid_read = (state_q == S_FREEZE) || (state_q == S_CAPTURE);

    always_comb begin
        cap_keys   = hid_keyboard_connected ? hid_keyboard_keycodes : '0;
        cap_mot[0] = hid_mouse_x;
        cap_mot[1] = hid_mouse_y;
        cap_mot[2] = hid_mouse_wheel;
        cap_roll   = 1'b0;
        for (int i = 0; i < 6; i++)
            if (cap_keys[i*8 +: 8] >= 8'h01 && cap_keys[i*8 +: 8] <= 8'h03)
                cap_roll = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (timer_q == POLL_END) begin
                    state_d = S_FREEZE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_FREEZE: begin
                if (timer_q == FRZ_END) begin
                    state_d = S_CAPTURE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d = S_SCAN;
                step_d  = '0;
            end
            S_SCAN: begin
                if (step_q == 5'd16) state_d = S_DONE;
                else step_d = step_q + 5'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        is_mod   = step_q == 5'd0;
        is_brk   = step_q >= 5'd1 && step_q <= 5'd6;
        is_mk    = step_q >= 5'd7 && step_q <= 5'd12;
        is_btn   = step_q == 5'd13;
        is_mot   = step_q >= 5'd14;
        brk_idx  = 3'(step_q - 5'd1);
        mk_idx   = 3'(step_q - 5'd7);
        ax       = is_mot ? 2'(step_q - 5'd14) : 2'd0;
        brk_code = key_at(prev_keys_q, brk_idx);
        mk_code  = key_at(cur_keys_q, mk_idx);
        diff     = signed'(cur_mot_q[ax] - last_q[ax]);
        if (diff > 32'sd127) clamped = 8'sd127;
        else if (diff < -32'sd127) clamped = -8'sd127;
        else clamped = diff[7:0];
        cand_v = 1'b0;
        cand_d = '0;
        if (state_q == S_SCAN) begin
            unique case (1'b1)
                is_mod: begin
                    cand_v = cur_mods_q != prev_mods_q;
                    cand_d = {8'h30, cur_mods_q};
                end
                is_brk: begin
                    cand_v = !roll_q && brk_code != '0 &&
                             !has_code(brk_code, cur_keys_q) &&
                             !seen_before(brk_code, prev_keys_q, brk_idx);
                    cand_d = {8'h20, brk_code};
                end
                is_mk: begin
                    cand_v = !roll_q && mk_code != '0 &&
                             !has_code(mk_code, prev_keys_q) &&
                             !seen_before(mk_code, cur_keys_q, mk_idx);
                    cand_d = {8'h10, mk_code};
                end
                is_btn: begin
                    cand_v = cur_btn_q != prev_btn_q;
                    cand_d = {8'h40, cur_btn_q};
                end
                is_mot: begin
                    cand_v = cur_mc_q && diff != '0;
                    cand_d = {2'b01, ax + 2'd1, 4'h0, clamped};
                end
                default: ;
            endcase
        end
    end

    assign evt_valid = cnt_q != '0;
    assign evt_count = cnt_q;
    assign evt_data  = evt_valid ? mem_q[rptr_q] : '0;
    assign overflow  = ovf_q;
    assign pop       = evt_valid && evt_ready;
    assign full      = cnt_q == FULL_CNT;
    assign push_ok   = cand_v && (!full || pop);

    always_comb begin
        cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        ovf_d = ovf_q;
        if (cand_v && !push_ok) ovf_d = 1'b1;
        else if (overflow_clr) ovf_d = 1'b0;
    end

    // motion residue stays in last_q until the delta actually enters the FIFO
    always_comb begin
        last_d = last_q;
        if (state_q == S_CAPTURE && !hid_mouse_connected)
            last_d = cap_mot;
        else if (push_ok && is_mot)
            last_d[ax] = last_q[ax] + {{24{clamped[7]}}, clamped};
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= cand_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            step_q      <= '0;
            cur_keys_q  <= '0;
            prev_keys_q <= '0;
            cur_mods_q  <= '0;
            prev_mods_q <= '0;
            cur_btn_q   <= '0;
            prev_btn_q  <= '0;
            cur_mc_q    <= 1'b0;
            roll_q      <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                last_q[i]    <= '0;
                cur_mot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (state_q == S_CAPTURE) begin
                cur_keys_q <= cap_keys;
                cur_mods_q <= hid_keyboard_connected ? hid_keyboard_modifiers : '0;
                cur_btn_q  <= hid_mouse_connected ? hid_mouse_buttons : '0;
                cur_mc_q   <= hid_mouse_connected;
                roll_q     <= cap_roll;
                cur_mot_q  <= cap_mot;
            end
            // rollover snapshots carry no key information worth remembering
            if (state_q == S_DONE) begin
                if (!roll_q) prev_keys_q <= cur_keys_q;
                prev_mods_q <= cur_mods_q;
                prev_btn_q  <= cur_btn_q;
            end
        end
    end
endmodule

// File: tb/tb_hid_event_encoder.sv
// tb_hid_event_encoder: snapshot-level reference model with per-cycle
// comparison, directed scenarios pinned to literal event lists, random traffic.
module tb_hid_event_encoder;
    localparam int POLL  = 8;
    localparam int FW    = 3;
    localparam int DEPTH = 16;
    localparam int P     = POLL + FW + 19;
    localparam int CAP   = POLL + FW;
    localparam int DONEP = POLL + FW + 18;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hid_read;
    logic        kb_conn, ms_conn;
    logic [7:0]  mods, btns;
    logic [47:0] keys;
    logic [31:0] mx, my, mw;
    logic [15:0] evt_data;
    logic        evt_valid, evt_ready;
    logic [4:0]  evt_count;
    logic        overflow, overflow_clr;

    always #5 clk = ~clk;

    hid_event_encoder #(.FIFO_DEPTH(DEPTH), .POLL_CYCLES(POLL), .FREEZE_WAIT(FW)) dut (
        .clk_i(clk), .rstn(rstn), .hid_read(hid_read),
        .hid_keyboard_connected(kb_conn), .hid_mouse_connected(ms_conn),
        .hid_keyboard_modifiers(mods), .hid_keyboard_keycodes(keys),
        .hid_mouse_buttons(btns), .hid_mouse_x(mx), .hid_mouse_y(my),
        .hid_mouse_wheel(mw), .evt_data(evt_data), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_count(evt_count), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    int n_vec = 0;
    int n_bad = 0;

    bit          m_on = 1'b0;
    bit          m_rst, m_ovf, e_rd;
    int          cnt;
    logic [15:0] mq[$], mlog[$], dlog[$], exq[$];
    logic [7:0]  pk[6], ck[6];
    logic [7:0]  pmod, cmod, pbtn, cbtn;
    logic [31:0] lastv[3], curv[3];
    bit          cmc, croll;
    bit          evv[14];
    logic [15:0] evd[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit member(input logic [7:0] c, input logic [7:0] a[6], input int upto);
        for (int j = 0; j < upto; j++)
            if (a[j] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovf = 1'b0;
        cnt   = 0;
        pmod  = '0;
        pbtn  = '0;
        cmod  = '0;
        cbtn  = '0;
        cmc   = 1'b0;
        croll = 1'b0;
        for (int i = 0; i < 6; i++) begin pk[i] = '0; ck[i] = '0; end
        for (int i = 0; i < 3; i++) begin lastv[i] = '0; curv[i] = '0; end
        for (int i = 0; i < 14; i++) begin evv[i] = 1'b0; evd[i] = '0; end
    endfunction

    // whole-snapshot diff: the key/modifier/button events of one poll, by slot order
    function automatic void m_capture();
        croll = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ck[i] = kb_conn ? keys[i*8 +: 8] : 8'h00;
            if (ck[i] >= 8'h01 && ck[i] <= 8'h03) croll = 1'b1;
        end
        cmod = kb_conn ? mods : 8'h00;
        cbtn = ms_conn ? btns : 8'h00;
        cmc  = ms_conn;
        curv[0] = mx; curv[1] = my; curv[2] = mw;
        if (!cmc) lastv = curv;
        for (int i = 0; i < 14; i++) begin evv[i] = 1'b0; evd[i] = '0; end
        evv[0] = cmod != pmod;
        evd[0] = {8'h30, cmod};
        if (!croll) begin
            for (int i = 0; i < 6; i++) begin
                if (pk[i] != 0 && !member(pk[i], ck, 6) && !member(pk[i], pk, i)) begin
                    evv[1+i] = 1'b1;
                    evd[1+i] = {8'h20, pk[i]};
                end
                if (ck[i] != 0 && !member(ck[i], pk, 6) && !member(ck[i], ck, i)) begin
                    evv[7+i] = 1'b1;
                    evd[7+i] = {8'h10, ck[i]};
                end
            end
        end
        evv[13] = cbtn != pbtn;
        evd[13] = {8'h40, cbtn};
    endfunction

    always @(posedge clk) begin : mdl
        bit pop, pv, mot, acc;
        logic [15:0] pd;
        logic [31:0] dv;
        int ph, s, a, cl, d;
        if (!rstn) begin
            m_reset();
            m_on  = 1'b1;
            m_rst = 1'b1;
            e_rd  = 1'b0;
        end else begin
            m_rst = 1'b0;
            ph  = cnt % P;
            pop = evt_ready && mq.size() > 0;
            pv = 1'b0; mot = 1'b0; pd = '0; a = 0; cl = 0;
            if (ph == CAP) m_capture();
            else if (ph > CAP && ph < DONEP) begin
                s = ph - CAP - 1;
                if (s < 14) begin
                    pv = evv[s];
                    pd = evd[s];
                end else begin
                    a   = s - 14;
                    dv  = curv[a] - lastv[a];
                    d   = dv;
                    cl  = d > 127 ? 127 : (d < -127 ? -127 : d);
                    mot = 1'b1;
                    pv  = cmc && d != 0;
                    pd  = {4'(5 + a), 4'h0, 8'(cl)};
                end
            end else if (ph == DONEP) begin
                if (!croll) pk = ck;
                pmod = cmod;
                pbtn = cbtn;
            end
            if (pop) mlog.push_back(mq.pop_front());
            acc = pv && mq.size() < DEPTH;
            if (acc) begin
                mq.push_back(pd);
                if (mot) lastv[a] = lastv[a] + cl;
            end
            if (pv && !acc) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            cnt++;
            ph   = cnt % P;
            e_rd = ph >= POLL && ph <= CAP;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            if (evt_valid && evt_ready && rstn) dlog.push_back(evt_data);
            chk("evt_valid", evt_valid, mq.size() != 0);
            chk("evt_count", evt_count, mq.size());
            if (mq.size() != 0) chk("evt_data", evt_data, mq[0]);
            if (m_rst) chk("rst_data", evt_data, 0);
            chk("overflow", overflow, m_ovf);
            chk("hid_read", hid_read, e_rd);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_log(input string nm);
        chk({nm, "_len"}, dlog.size(), exq.size());
        chk({nm, "_mlen"}, mlog.size(), exq.size());
        foreach (exq[i]) begin
            if (i < dlog.size()) chk(nm, dlog[i], exq[i]);
            if (i < mlog.size()) chk({nm, "_model"}, mlog[i], exq[i]);
        end
        dlog.delete();
        mlog.delete();
    endtask

    initial begin
        bit ok;
        int n, rp, r;
        logic [7:0] kb[6];
        rstn = 1'b0; kb_conn = 1'b1; ms_conn = 1'b1;
        mods = '0; btns = '0; keys = '0; mx = '0; my = '0; mw = '0;
        evt_ready = 1'b1; overflow_clr = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(2*P);
        exq = {}; expect_log("idle");

        keys = 48'h04; tick(2*P);
        exq = {16'h1004}; expect_log("press");
        keys = 48'h05; mods = 8'h02; tick(2*P);
        exq = {16'h3002, 16'h2004, 16'h1005}; expect_log("change");
        keys = '0; mods = '0; tick(2*P);
        exq = {16'h3000, 16'h2005}; expect_log("release");
        keys = 48'h04; tick(2*P);
        exq = {16'h1004}; expect_log("repress");

        keys = 48'h01_01_01_01_01_01; tick(2*P);
        exq = {}; expect_log("rollover");
        keys = '0; tick(2*P);
        exq = {16'h2004}; expect_log("roll_release");

        mx = 32'd300; tick(4*P);
        exq = {16'h507F, 16'h507F, 16'h502E}; expect_log("dx_residue");
        my = 32'hFFFF_FFFB; mw = 32'd2; btns = 8'h01; tick(2*P);
        exq = {16'h4001, 16'h60FB, 16'h7002}; expect_log("btn_dy_wheel");

        evt_ready = 1'b0;
        keys = 48'h09_08_07_06_05_04; mods = 8'h01; tick(2*P);
        keys = 48'h0F_0E_0D_0C_0B_0A; mods = 8'h03; tick(2*P);
        chk("full_count", evt_count, 16);
        chk("full_ovf", overflow, 1);
        overflow_clr = 1'b1; tick(1);
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
        evt_ready = 1'b1; tick(2*P);
        exq = {16'h3001, 16'h1004, 16'h1005, 16'h1006, 16'h1007, 16'h1008, 16'h1009,
               16'h3003, 16'h2004, 16'h2005, 16'h2006, 16'h2007, 16'h2008, 16'h2009,
               16'h100A, 16'h100B};
        expect_log("drain");
        keys = '0; mods = '0; tick(2*P);
        exq = {16'h3000, 16'h200A, 16'h200B, 16'h200C, 16'h200D, 16'h200E, 16'h200F};
        expect_log("lost_keys_release");

        for (int k = 0; k < 120; k++) begin
            for (int i = 0; i < 6; i++) begin
                r = $urandom_range(0, 99);
                kb[i] = r < 50 ? 8'h00 : (r < 54 ? 8'($urandom_range(1, 3)) : 8'($urandom_range(4, 12)));
            end
            keys = {kb[5], kb[4], kb[3], kb[2], kb[1], kb[0]};
            mods = 8'($urandom_range(0, 3));
            btns = 8'($urandom_range(0, 3));
            kb_conn = $urandom_range(0, 9) != 0;
            ms_conn = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 19) == 0) mx = $urandom();
            else mx = mx + 32'($urandom_range(0, 800)) - 32'd400;
            my = my + 32'($urandom_range(0, 300)) - 32'd150;
            mw = mw + 32'($urandom_range(0, 6)) - 32'd3;
            rp = $urandom_range(0, 1) ? 90 : 15;
            n  = $urandom_range(5, 40);
            for (int c = 0; c < n; c++) begin
                evt_ready    = $urandom_range(0, 99) < rp;
                overflow_clr = $urandom_range(0, 99) < 4;
                tick(1);
            end
        end
        evt_ready = 1'b1; overflow_clr = 1'b0; kb_conn = 1'b1; ms_conn = 1'b1;
        tick(2*P);

        keys = 48'h20; mods = 8'h11;
        ok = 1'b0;
        for (int c = 0; c < 2*P && !ok; c++) begin tick(1); if (hid_read) ok = 1'b1; end
        chk("wait_freeze", ok, 1);
        ok = 1'b0;
        for (int c = 0; c < 2*P && !ok; c++) begin tick(1); if (!hid_read) ok = 1'b1; end
        chk("wait_scan", ok, 1);
        tick(2);
        rstn = 1'b0;
        keys = '0; mods = '0; btns = '0; mx = '0; my = '0; mw = '0;
        tick(1);
        chk("rst_valid", evt_valid, 0);
        chk("rst_read", hid_read, 0);
        chk("rst_count", evt_count, 0);
        tick(1);
        rstn = 1'b1;
        dlog.delete(); mlog.delete();
        tick(2*P);
        exq = {}; expect_log("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
